// File: rtl/delay_pkg.sv
// Shared definitions for the programmable delay line.
//   - default parameter constants
//   - clog2 helper and the width rules derived from it:
//       delay_w(M) : bits needed to hold a delay/fill value 0..M
//       ptr_w(M)   : bits needed to index a storage slot 0..M-1 (never below 1)
package delay_pkg;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_CHANNELS     = 1;
   localparam int DEF_MAX_DELAY    = 16;
   localparam int DEF_ZERO_INVALID = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int delay_w(input int max_delay);
      return clog2(max_delay + 1);
   endfunction

   function automatic int ptr_w(input int max_delay);
      return (max_delay > 1) ? clog2(max_delay) : 1;
   endfunction

endpackage

// File: rtl/delay_line_prog_if.sv
// Stream/control bundle of the programmable delay line.
// Signals:
//   CLK_en     advance enable (line frozen when 0)
//   Flush_in   synchronous flush of valid state
//   Delay_sel  requested delay in enabled cycles
//   Input      sample, channel k at [k*WIDTH +: WIDTH]
//   Valid_in   sample valid
//   Output     delayed sample
//   Valid_out  delayed valid, gated by fill level
//   Fill_cnt   enabled writes since reset/flush, saturating at MAX_DELAY
//   Sel_err    Delay_sel above MAX_DELAY (combinational)
// master drives the stream, slave is the delay line.
interface delay_line_prog_if
   import delay_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CHANNELS  = DEF_CHANNELS,
   parameter int MAX_DELAY = DEF_MAX_DELAY
);
   localparam int DELAY_W = delay_w(MAX_DELAY);

   logic                        CLK_en;
   logic                        Flush_in;
   logic [DELAY_W-1:0]          Delay_sel;
   logic [WIDTH*CHANNELS-1:0]   Input;
   logic                        Valid_in;
   logic [WIDTH*CHANNELS-1:0]   Output;
   logic                        Valid_out;
   logic [DELAY_W-1:0]          Fill_cnt;
   logic                        Sel_err;

   modport master (
      output CLK_en, Flush_in, Delay_sel, Input, Valid_in,
      input  Output, Valid_out, Fill_cnt, Sel_err
   );

   modport slave (
      input  CLK_en, Flush_in, Delay_sel, Input, Valid_in,
      output Output, Valid_out, Fill_cnt, Sel_err
   );

endinterface

// File: rtl/delay_ptr_ctrl.sv
// Pointer and fill bookkeeping for the circular delay buffer.
// Ports:
//   CLK_in, RST_in  clock, synchronous active-high reset
//   clk_en          advance wp/fill by one slot
//   flush           return wp/fill to empty (lower priority than reset)
//   delay_sel       requested delay
//   wp              current write slot
//   rd_idx          slot holding the sample written deff enabled edges ago
//   fill            writes since reset/flush, saturating at MAX_DELAY
//   deff            delay_sel clamped to MAX_DELAY
//   sel_err         delay_sel was clamped
module delay_ptr_ctrl
   import delay_pkg::*;
#(
   parameter int MAX_DELAY = DEF_MAX_DELAY,
   parameter int DELAY_W   = delay_w(MAX_DELAY),
   parameter int PTR_W     = ptr_w(MAX_DELAY)
) (
   input  logic               CLK_in,
   input  logic               RST_in,
   input  logic               clk_en,
   input  logic               flush,
   input  logic [DELAY_W-1:0] delay_sel,
   output logic [PTR_W-1:0]   wp,
   output logic [PTR_W-1:0]   rd_idx,
   output logic [DELAY_W-1:0] fill,
   output logic [DELAY_W-1:0] deff,
   output logic               sel_err
);

   localparam logic [DELAY_W-1:0] MAX_D   = DELAY_W'(MAX_DELAY);
   localparam logic [DELAY_W:0]   MAX_EXT = (DELAY_W+1)'(MAX_DELAY);
   localparam logic [PTR_W-1:0]   LAST_WP = PTR_W'(MAX_DELAY - 1);

   logic [DELAY_W:0] rd_sum;
   logic [DELAY_W:0] rd_mod;

   always_comb begin
      sel_err = (delay_sel > MAX_D);
      deff    = sel_err ? MAX_D : delay_sel;
   end

   always_ff @(posedge CLK_in) begin
      if (RST_in || flush) begin
         wp   <= '0;
         fill <= '0;
      end else if (clk_en) begin
         wp <= (wp == LAST_WP) ? '0 : wp + 1'b1;
         if (fill != MAX_D)
            fill <= fill + 1'b1;
      end
   end

   // wp + MAX_DELAY - deff lies in [0, 2*MAX_DELAY-1] for deff in 0..MAX_DELAY,
   // so one conditional subtract gives the modulo without a divider.
   always_comb begin
      rd_sum = (DELAY_W+1)'(wp) + MAX_EXT - {1'b0, deff};
      rd_mod = (rd_sum >= MAX_EXT) ? rd_sum - MAX_EXT : rd_sum;
   end

   assign rd_idx = PTR_W'(rd_mod);

endmodule

// File: rtl/delay_line_prog.sv
// Multi-channel delay line with clock enable and a run-time delay of
// 0..MAX_DELAY enabled cycles. A valid bit travels with each sample and the
// output valid is additionally gated by the fill level, so stale storage is
// never presented as real data.
// Ports:
//   CLK_in  clock
//   RST_in  synchronous active-high reset (clears data and valid)
//   bus     delay_line_prog_if.slave (stream in/out, enable, flush, delay,
//           fill count, select error)
module delay_line_prog
   import delay_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int CHANNELS     = DEF_CHANNELS,
   parameter int MAX_DELAY    = DEF_MAX_DELAY,
   parameter int ZERO_INVALID = DEF_ZERO_INVALID
) (
   input  logic                CLK_in,
   input  logic                RST_in,
   delay_line_prog_if.slave    bus
);

   localparam int DW      = WIDTH * CHANNELS;
   localparam int DELAY_W = delay_w(MAX_DELAY);
   localparam int PTR_W   = ptr_w(MAX_DELAY);

   logic [DW-1:0]      mem_d [MAX_DELAY];
   logic               mem_v [MAX_DELAY];

   logic [PTR_W-1:0]   wp;
   logic [PTR_W-1:0]   rd_idx;
   logic [DELAY_W-1:0] fill;
   logic [DELAY_W-1:0] deff;
   logic               sel_err;

   logic [DW-1:0]      out_d;
   logic               out_v;

   delay_ptr_ctrl #(
      .MAX_DELAY (MAX_DELAY),
      .DELAY_W   (DELAY_W),
      .PTR_W     (PTR_W)
   ) u_ptr (
      .CLK_in    (CLK_in),
      .RST_in    (RST_in),
      .clk_en    (bus.CLK_en),
      .flush     (bus.Flush_in),
      .delay_sel (bus.Delay_sel),
      .wp        (wp),
      .rd_idx    (rd_idx),
      .fill      (fill),
      .deff      (deff),
      .sel_err   (sel_err)
   );

   // Flush only invalidates; the data words are left as they were.
   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         for (int i = 0; i < MAX_DELAY; i++) begin
            mem_d[i] <= '0;
            mem_v[i] <= 1'b0;
         end
      end else if (bus.Flush_in) begin
         for (int i = 0; i < MAX_DELAY; i++)
            mem_v[i] <= 1'b0;
      end else if (bus.CLK_en) begin
         mem_d[wp] <= bus.Input;
         mem_v[wp] <= bus.Valid_in;
      end
   end

   // Zero delay bypasses storage entirely, so it is valid regardless of fill.
   always_comb begin
      out_d = mem_d[rd_idx];
      out_v = mem_v[rd_idx] && (fill >= deff);
      if (deff == '0) begin
         out_d = bus.Input;
         out_v = bus.Valid_in;
      end
      if ((ZERO_INVALID != 0) && !out_v)
         out_d = '0;
   end

   always_comb begin
      bus.Output    = out_d;
      bus.Valid_out = out_v;
      bus.Fill_cnt  = fill;
      bus.Sel_err   = sel_err;
   end

endmodule

// File: tb/tb_delay_line_prog.sv
module tb_delay_line_prog;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   typedef struct {
      int    cyc;
      int    dut;
      string nm;
      logic  ev;
      int    ed;
      int    ef;
      logic  eerr;
   } exp_t;

   exp_t sb[$];

   delay_line_prog_if #(.WIDTH(8), .CHANNELS(1), .MAX_DELAY(16)) bus0 ();
   delay_line_prog_if #(.WIDTH(8), .CHANNELS(1), .MAX_DELAY(5))  bus1 ();

   delay_line_prog #(.WIDTH(8), .CHANNELS(1), .MAX_DELAY(16), .ZERO_INVALID(1)) dut0 (
      .CLK_in (clk),
      .RST_in (rst),
      .bus    (bus0)
   );

   delay_line_prog #(.WIDTH(8), .CHANNELS(1), .MAX_DELAY(5), .ZERO_INVALID(1)) dut1 (
      .CLK_in (clk),
      .RST_in (rst),
      .bus    (bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t       e;
         logic       av;
         logic [7:0] ad;
         logic [7:0] edv;
         logic [4:0] af;
         logic [4:0] efv;
         logic       ae;
         e = sb.pop_front();
         if (e.dut == 0) begin
            av = bus0.Valid_out;
            ad = bus0.Output;
            af = bus0.Fill_cnt;
            ae = bus0.Sel_err;
         end else begin
            av = bus1.Valid_out;
            ad = bus1.Output;
            af = {2'b00, bus1.Fill_cnt};
            ae = bus1.Sel_err;
         end
         edv = e.ed[7:0];
         efv = e.ef[4:0];
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s stale: scheduled %0d seen %0d", e.nm, e.cyc, cyc);
         end
         checks++;
         if (av !== e.ev) begin
            errors++;
            $display("FAIL %s valid: got %0b want %0b", e.nm, av, e.ev);
         end
         checks++;
         if (ad !== edv) begin
            errors++;
            $display("FAIL %s data: got %0d want %0d", e.nm, ad, edv);
         end
         checks++;
         if (af !== efv) begin
            errors++;
            $display("FAIL %s fill: got %0d want %0d", e.nm, af, efv);
         end
         checks++;
         if (ae !== e.eerr) begin
            errors++;
            $display("FAIL %s sel_err: got %0b want %0b", e.nm, ae, e.eerr);
         end
      end
   end

   // Drive one cycle of inputs, post the expected combinational response for
   // this cycle, then let the clock edge consume the inputs.
   task automatic step(input int dut, input logic en, input logic fl, input int d,
                       input int din, input logic vin, input logic ev, input int ed,
                       input int ef, input logic eerr, input string nm);
      exp_t e;
      if (dut == 0) begin
         bus0.CLK_en    = en;
         bus0.Flush_in  = fl;
         bus0.Delay_sel = 5'(d);
         bus0.Input     = 8'(din);
         bus0.Valid_in  = vin;
      end else begin
         bus1.CLK_en    = en;
         bus1.Flush_in  = fl;
         bus1.Delay_sel = 3'(d);
         bus1.Input     = 8'(din);
         bus1.Valid_in  = vin;
      end
      e.cyc  = cyc;
      e.dut  = dut;
      e.nm   = nm;
      e.ev   = ev;
      e.ed   = ed;
      e.ef   = ef;
      e.eerr = eerr;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus0.CLK_en = 1'b0; bus0.Flush_in = 1'b0; bus0.Delay_sel = '0;
      bus0.Input = '0; bus0.Valid_in = 1'b0;
      bus1.CLK_en = 1'b0; bus1.Flush_in = 1'b0; bus1.Delay_sel = '0;
      bus1.Input = '0; bus1.Valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      step(0, 1, 0, 3, 8'h55, 1, 0, 0, 0, 0, "rst0");
      step(1, 0, 0, 5, 3,     1, 0, 0, 0, 0, "rst1");
      rst = 1'b0;

      // D=3 fill-up and first outputs
      step(0, 1, 0, 3, 1, 1, 0, 0, 0, 0, "t1_c1");
      step(0, 1, 0, 3, 2, 1, 0, 0, 1, 0, "t1_c2");
      step(0, 1, 0, 3, 3, 1, 0, 0, 2, 0, "t1_c3");
      step(0, 1, 0, 3, 4, 1, 1, 1, 3, 0, "t1_c4");
      step(0, 1, 0, 3, 5, 1, 1, 2, 4, 0, "t1_c5");
      step(0, 1, 0, 3, 6, 1, 1, 3, 5, 0, "t1_c6");
      step(0, 1, 1, 3, 8'h63, 1, 1, 4, 6, 0, "t1_flush");

      // clock-enable gaps
      step(0, 1, 0, 3, 10, 1, 0, 0, 0, 0, "t2_0");
      step(0, 0, 0, 3, 11, 1, 0, 0, 1, 0, "t2_1");
      step(0, 1, 0, 3, 12, 1, 0, 0, 1, 0, "t2_2");
      step(0, 0, 0, 3, 13, 1, 0, 0, 2, 0, "t2_3");
      step(0, 1, 0, 3, 14, 1, 0, 0, 2, 0, "t2_4");
      step(0, 1, 0, 3, 15, 1, 1, 10, 3, 0, "t2_5");
      step(0, 0, 0, 3, 16, 1, 1, 12, 4, 0, "t2_6");
      step(0, 0, 0, 3, 17, 1, 1, 12, 4, 0, "t2_hold");

      // zero-delay pass-through
      step(0, 0, 0, 0, 8'hA5, 1, 1, 8'hA5, 4, 0, "t3_pass");
      step(0, 0, 0, 0, 8'h5A, 0, 0, 0,     4, 0, "t3_inval");

      // delay change, then flush and refill
      step(0, 1, 0, 2, 20, 1, 1, 14, 4, 0, "t5_d2a");
      step(0, 1, 0, 2, 21, 1, 1, 15, 5, 0, "t5_d2b");
      step(0, 1, 0, 4, 22, 1, 1, 14, 6, 0, "t5_d4a");
      step(0, 1, 0, 4, 23, 1, 1, 15, 7, 0, "t5_d4b");
      step(0, 1, 1, 4, 99, 1, 1, 20, 8, 0, "t5_flush");
      step(0, 1, 0, 4, 30, 1, 0, 0, 0, 0, "t5_r0");
      step(0, 1, 0, 4, 31, 1, 0, 0, 1, 0, "t5_r1");
      step(0, 1, 0, 4, 32, 1, 0, 0, 2, 0, "t5_r2");
      step(0, 1, 0, 4, 33, 1, 0, 0, 3, 0, "t5_r3");
      step(0, 1, 0, 4, 34, 1, 1, 30, 4, 0, "t5_r4");

      // flush discards the concurrent sample
      step(0, 1, 1, 4, 7, 1, 1, 31, 5, 0, "t6_flush7");
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "t6_empty");
      step(0, 1, 0, 1, 8, 1, 0, 0, 0, 0, "t6_w8");
      step(0, 1, 0, 1, 9, 1, 1, 8, 1, 0, "t6_out8");
      step(0, 1, 0, 1, 8'h44, 0, 1, 9, 2, 0, "t6_out9");
      step(0, 0, 0, 1, 0, 1, 0, 0, 3, 0, "t6_vbit");

      // clamp: Delay_sel=20 behaves as 16
      step(0, 0, 1, 1, 0, 0, 0, 0, 3, 0, "t6_flush");
      for (int i = 0; i < 16; i++)
         step(0, 1, 0, 20, 40 + i, 1, 0, 0, i, 1, "t6_clamp_fill");
      step(0, 0, 0, 20, 0, 0, 1, 40, 16, 1, "t6_clamp20");
      step(0, 0, 0, 16, 0, 0, 1, 40, 16, 0, "t6_d16");
      step(0, 0, 0, 15, 0, 0, 1, 41, 16, 0, "t6_d15");
      step(0, 1, 0, 20, 56, 1, 1, 40, 16, 1, "t6_sat_w");
      step(0, 0, 0, 20, 0, 0, 1, 41, 16, 1, "t6_sat");

      // reset mid-stream wipes everything
      rst = 1'b1;
      step(0, 0, 0, 16, 0, 0, 1, 41, 16, 0, "t7_pre_rst");
      rst = 1'b0;
      step(0, 0, 0, 16, 0, 0, 0, 0, 0, 0, "t7_post_rst");
      bus0.CLK_en = 1'b0;

      // MAX_DELAY=5 wrap and saturation
      for (int n = 1; n <= 12; n++)
         step(1, 1, 0, 5, n, 1, (n >= 6), (n >= 6) ? n - 5 : 0,
              (n - 1 < 5) ? n - 1 : 5, 0, "t4_wrap");
      step(1, 0, 0, 7, 0, 0, 1, 8, 5, 1, "t4_clamp");

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
